slp_update_fxp_weights: RTL and testbench

Sequential, time-multiplexed weight-update engine for a single-layer perceptron with N fixed-point weights. It computes `new_weight[k] = weight[k] + in[k] * (rate * error)` for k = 0..N-1, using one shared multiplier/adder datapath and a valid/ready handshake. It sits between the forward-path error calculation and the weight register file, and replaces per-weight combinational update instances with one pipelined unit.

---
 rtl/slp_update_fxp_weights.sv | 277 +++++++++++++++++++++++++++
 tb/tb_slp_update_fxp_weights.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/slp_update_fxp_weights.sv
// -----------------------------------------------------------------------------
// slp_update_fxp_weights
//
// Time-multiplexed weight-update engine for a single-layer perceptron:
//    new_weight[k] = weight[k] + in[k] * (rate * error),  k = 0..N-1
// One shared multiplier pipeline processes one channel per cycle. Every
// intermediate value is exact; precision is lost only in the final reduction
// to the weight format.
//
// Each fixed-point format is flattened into three parameters:
//    <X>_PREC (total bits), <X>_FRAC (fractional bits), <X>_SIGNED (1 = two's
//    complement). X = I (samples), R (rate), P (error), W (weights).
//
// Optional build macro:
//    SLP_UPD_SAT_EN  defined   -> out-of-range channels clamp to W max / min
//                    undefined -> out-of-range channels wrap to W_PREC bits
//
// Ports:
//    clk         rising-edge clock
//    reset_      asynchronous active-low reset
//    in_valid    request valid
//    in_ready    engine idle; request accepted on in_valid && in_ready
//    in          N samples, channel k at [k*I_PREC +: I_PREC]
//    rate        learning rate
//    error       output error
//    weight      N current weights, same packing as in
//    out_valid   result valid (held until out_ready)
//    out_ready   consumer accepts result
//    new_weight  N updated weights
//    ovf         some channel exceeded the weight maximum
//    udf         some channel fell below the weight minimum
//    rounded     some channel lost fractional bits
//    ovf_mask    per-channel ovf | udf
// -----------------------------------------------------------------------------
module slp_update_fxp_weights #(
   parameter int N        = 4,
   parameter int I_PREC   = 16,
   parameter int I_FRAC   = 8,
   parameter bit I_SIGNED = 1'b1,
   parameter int R_PREC   = 16,
   parameter int R_FRAC   = 8,
   parameter bit R_SIGNED = 1'b1,
   parameter int P_PREC   = 16,
   parameter int P_FRAC   = 8,
   parameter bit P_SIGNED = 1'b1,
   parameter int W_PREC   = 16,
   parameter int W_FRAC   = 8,
   parameter bit W_SIGNED = 1'b1
) (
   input  logic                clk,
   input  logic                reset_,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [N*I_PREC-1:0] in,
   input  logic [R_PREC-1:0]   rate,
   input  logic [P_PREC-1:0]   error,
   input  logic [N*W_PREC-1:0] weight,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [N*W_PREC-1:0] new_weight,
   output logic                ovf,
   output logic                udf,
   output logic                rounded,
   output logic [N-1:0]        ovf_mask
);

   // rate*error at full precision
   localparam int RE_PREC   = R_PREC + P_PREC;
   localparam bit RE_SIGNED = R_SIGNED | P_SIGNED;
   // in*RE at full precision
   localparam int PR_PREC   = I_PREC + RE_PREC;
   localparam int PR_FRAC   = I_FRAC + R_FRAC + P_FRAC;
   localparam bit PR_SIGNED = I_SIGNED | RE_SIGNED;
   // Sum format: wide enough for either addend plus carry and a sign bit
   localparam int PR_INT    = PR_PREC - PR_FRAC;
   localparam int W_INT     = W_PREC - W_FRAC;
   localparam int S_FRAC    = (PR_FRAC > W_FRAC) ? PR_FRAC : W_FRAC;
   localparam int S_INT     = ((PR_INT > W_INT) ? PR_INT : W_INT) + 2;
   localparam int S_W       = S_INT + S_FRAC;
   localparam int SH_PR     = S_FRAC - PR_FRAC;
   localparam int SH_W      = S_FRAC - W_FRAC;
   localparam int IDX_W     = (N > 1) ? $clog2(N) : 1;

   localparam logic [IDX_W-1:0]      IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(N - 1);
   localparam logic signed [S_W-1:0] ONE_S    = S_W'(1);
   localparam logic signed [S_W-1:0] RND_MASK = (ONE_S <<< SH_W) - ONE_S;
   localparam logic signed [S_W-1:0] W_MAX_S  = W_SIGNED ? ((ONE_S <<< (W_PREC - 1)) - ONE_S)
                                                         : ((ONE_S <<< W_PREC) - ONE_S);
   localparam logic signed [S_W-1:0] W_MIN_S  = W_SIGNED ? (-(ONE_S <<< (W_PREC - 1)))
                                                         : {S_W{1'b0}};

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PRE   = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t              state_r;
   state_t              next_state_s;
   logic [IDX_W-1:0]    idx_r;
   logic                drain_r;
   logic                accept_s;

   logic [I_PREC-1:0]   in_r     [N];
   logic [W_PREC-1:0]   weight_r [N];
   logic [W_PREC-1:0]   nw_r     [N];
   logic [R_PREC-1:0]   rate_r;
   logic [P_PREC-1:0]   error_r;
   logic [RE_PREC-1:0]  re_r;
   logic [PR_PREC-1:0]  prod_r;
   logic                p1_valid_r;
   logic [IDX_W-1:0]    p1_idx_r;

   logic [RE_PREC-1:0]  rate_x_s;
   logic [RE_PREC-1:0]  error_x_s;
   logic [RE_PREC-1:0]  re_full_s;
   logic [I_PREC-1:0]   in_ch_s;
   logic [PR_PREC-1:0]  in_x_s;
   logic [PR_PREC-1:0]  re_x_s;
   logic [PR_PREC-1:0]  prod_full_s;
   logic [W_PREC-1:0]   w_ch_s;
   logic signed [S_W-1:0] prod_al_s;
   logic signed [S_W-1:0] w_al_s;
   logic signed [S_W-1:0] sum_s;
   logic signed [S_W-1:0] red_s;
   logic                ch_ovf_s;
   logic                ch_udf_s;
   logic                ch_rnd_s;
   logic [W_PREC-1:0]   ch_res_s;

   assign accept_s = in_valid && in_ready;

   // Present the per-channel result registers as the packed output bus.
   for (genvar g = 0; g < N; g++) begin : g_pack
      assign new_weight[g*W_PREC +: W_PREC] = nw_r[g];
   end

   // Sequencing FSM next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) next_state_s = ST_PRE;
            else          next_state_s = ST_IDLE;
         end
         ST_PRE:  next_state_s = ST_RUN;
         ST_RUN: begin
            if (idx_r == IDX_LAST) next_state_s = ST_DRAIN;
            else                   next_state_s = ST_RUN;
         end
         ST_DRAIN: begin
            if (drain_r) next_state_s = ST_DONE;
            else         next_state_s = ST_DRAIN;
         end
         ST_DONE: begin
            if (out_ready) next_state_s = ST_IDLE;
            else           next_state_s = ST_DONE;
         end
         default: next_state_s = ST_IDLE;
      endcase
   end

   // FSM state, channel/drain counters and registered handshake outputs.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_r   <= ST_IDLE;
         idx_r     <= '0;
         drain_r   <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         state_r   <= next_state_s;
         in_ready  <= (next_state_s == ST_IDLE);
         out_valid <= (next_state_s == ST_DONE);
         if ((state_r == ST_RUN) && (idx_r != IDX_LAST)) idx_r <= idx_r + IDX_ONE;
         else                                             idx_r <= '0;
         // Two-cycle drain: toggles 0 -> 1 while draining, 0 elsewhere
         drain_r   <= (state_r == ST_DRAIN) ? ~drain_r : 1'b0;
      end
   end

   // Request capture on accept and the rate*error pre-product.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         for (int k = 0; k < N; k++) begin
            in_r[k]     <= '0;
            weight_r[k] <= '0;
         end
         rate_r  <= '0;
         error_r <= '0;
         re_r    <= '0;
      end else begin
         if (accept_s) begin
            for (int k = 0; k < N; k++) begin
               in_r[k]     <= in[k*I_PREC +: I_PREC];
               weight_r[k] <= weight[k*W_PREC +: W_PREC];
            end
            rate_r  <= rate;
            error_r <= error;
         end
         if (state_r == ST_PRE) re_r <= re_full_s;
      end
   end

   // Multiplier and reduction datapath. Operands are extended to the product
   // width by their own signedness, so the modular product is exact.
   always_comb begin
      rate_x_s    = {{P_PREC{R_SIGNED & rate_r[R_PREC-1]}}, rate_r};
      error_x_s   = {{R_PREC{P_SIGNED & error_r[P_PREC-1]}}, error_r};
      re_full_s   = rate_x_s * error_x_s;

      in_ch_s     = in_r[idx_r];
      in_x_s      = {{RE_PREC{I_SIGNED & in_ch_s[I_PREC-1]}}, in_ch_s};
      re_x_s      = {{I_PREC{RE_SIGNED & re_r[RE_PREC-1]}}, re_r};
      prod_full_s = in_x_s * re_x_s;

      // Align both addends to the common binary point, then add exactly
      w_ch_s      = weight_r[p1_idx_r];
      prod_al_s   = {{(S_W-PR_PREC){PR_SIGNED & prod_r[PR_PREC-1]}}, prod_r};
      prod_al_s   = prod_al_s <<< SH_PR;
      w_al_s      = {{(S_W-W_PREC){W_SIGNED & w_ch_s[W_PREC-1]}}, w_ch_s};
      w_al_s      = w_al_s <<< SH_W;
      sum_s       = prod_al_s + w_al_s;

      // Reduction to the weight format drops the extra fraction bits
      red_s       = sum_s >>> SH_W;
      ch_rnd_s    = |(sum_s & RND_MASK);
      ch_ovf_s    = (red_s > W_MAX_S);
      ch_udf_s    = (red_s < W_MIN_S);
`ifdef SLP_UPD_SAT_EN
      if (ch_ovf_s)      ch_res_s = W_MAX_S[W_PREC-1:0];
      else if (ch_udf_s) ch_res_s = W_MIN_S[W_PREC-1:0];
      else               ch_res_s = red_s[W_PREC-1:0];
`else
      ch_res_s    = red_s[W_PREC-1:0];
`endif
   end

   // Pipeline stage 1: per-channel product register.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         prod_r     <= '0;
         p1_valid_r <= 1'b0;
         p1_idx_r   <= '0;
      end else begin
         p1_valid_r <= (state_r == ST_RUN);
         p1_idx_r   <= idx_r;
         if (state_r == ST_RUN) prod_r <= prod_full_s;
      end
   end

   // Pipeline stage 2: result/flag write-back; flags clear on accept.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         for (int k = 0; k < N; k++) nw_r[k] <= '0;
         ovf      <= 1'b0;
         udf      <= 1'b0;
         rounded  <= 1'b0;
         ovf_mask <= '0;
      end else if (accept_s) begin
         ovf      <= 1'b0;
         udf      <= 1'b0;
         rounded  <= 1'b0;
         ovf_mask <= '0;
      end else if (p1_valid_r) begin
         nw_r[p1_idx_r]     <= ch_res_s;
         ovf_mask[p1_idx_r] <= ch_ovf_s | ch_udf_s;
         ovf                <= ovf | ch_ovf_s;
         udf                <= udf | ch_udf_s;
         rounded            <= rounded | ch_rnd_s;
      end
   end

endmodule

// File: tb/tb_slp_update_fxp_weights.sv
// Directed bench for slp_update_fxp_weights: signed Q8.8 everywhere, N = 4.
module tb_slp_update_fxp_weights;

   logic        clk = 1'b0;
   logic        reset_;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in;
   logic [15:0] rate;
   logic [15:0] error;
   logic [63:0] weight;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] new_weight;
   logic        ovf;
   logic        udf;
   logic        rounded;
   logic [3:0]  ovf_mask;

   int cmp_cnt = 0;
   int err_cnt = 0;

`ifdef SLP_UPD_SAT_EN
   localparam logic [63:0] EXP_OVF_NW = 64'h0200_7FFF_0200_0200;
   localparam logic [63:0] EXP_UDF_NW = 64'hFF00_FE00_0100_8000;
`else
   localparam logic [63:0] EXP_OVF_NW = 64'h0200_8100_0200_0200;
   localparam logic [63:0] EXP_UDF_NW = 64'hFF00_FE00_0100_7F00;
`endif

   slp_update_fxp_weights dut (
      .clk        (clk),
      .reset_     (reset_),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in         (in),
      .rate       (rate),
      .error      (error),
      .weight     (weight),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .new_weight (new_weight),
      .ovf        (ovf),
      .udf        (udf),
      .rounded    (rounded),
      .ovf_mask   (ovf_mask)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      cmp_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_result(input string tag, input logic [63:0] nw,
                               input logic [2:0] flags, input logic [3:0] mask);
      check({tag, "_nw"}, new_weight, nw);
      check({tag, "_flags"}, {61'd0, ovf, udf, rounded}, {61'd0, flags});
      check({tag, "_mask"}, {60'd0, ovf_mask}, {60'd0, mask});
   endtask

   // Drive one request; returns 1 ns after the accept edge with inputs scrambled.
   task automatic start_txn(input string tag, input logic [63:0] vin, input logic [63:0] vw,
                            input logic [15:0] r, input logic [15:0] e);
      @(negedge clk);
      check({tag, "_ready_idle"}, {63'd0, in_ready}, 64'd1);
      in = vin; weight = vw; rate = r; error = e; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in = 64'hDEAD_BEEF_1357_9BDF; weight = 64'h7654_3210_FEDC_BA98;
      rate = 16'h7777; error = 16'h5555;
      check({tag, "_ready_busy"}, {63'd0, in_ready}, 64'd0);
   endtask

   // Count edges from the accept edge until out_valid shows; expect 7.
   task automatic wait_valid(input string tag);
      int lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'd7);
   endtask

   task automatic handshake(input string tag);
      @(posedge clk); #1;
      check({tag, "_hs_ready"}, {63'd0, in_ready}, 64'd1);
      check({tag, "_hs_valid"}, {63'd0, out_valid}, 64'd0);
   endtask

   initial begin
      int seen;
      reset_ = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in = 64'd0; weight = 64'd0; rate = 16'd0; error = 16'd0;
      repeat (2) @(negedge clk);
      check("rst_ready", {63'd0, in_ready}, 64'd1);
      check("rst_valid", {63'd0, out_valid}, 64'd0);
      check_result("rst", 64'd0, 3'b000, 4'b0000);
      reset_ = 1'b1;

      // Basic: RE = 0.5*2.0 = 1.0, each weight += 1.0
      start_txn("basic", 64'h0100_0100_0100_0100, 64'h0100_FFC0_0000_0040, 16'h0080, 16'h0200);
      wait_valid("basic");
      check_result("basic", 64'h0200_00C0_0100_0140, 3'b000, 4'b0000);
      handshake("basic");

      // Overflow on channel 2: 127.0 + 2.0
      start_txn("ovf", 64'h0100_0100_0100_0100, 64'h0000_7F00_0000_0000, 16'h0100, 16'h0200);
      wait_valid("ovf");
      check_result("ovf", EXP_OVF_NW, 3'b100, 4'b0100);
      handshake("ovf");

      // Underflow on channel 0: -127.0 - 2.0
      start_txn("udf", 64'h0100_0100_0100_0100, 64'h0100_0000_0300_8100, 16'h0100, 16'hFE00);
      wait_valid("udf");
      check_result("udf", EXP_UDF_NW, 3'b010, 4'b0001);
      handshake("udf");

      // Rounding: channel 1 delta is 2^-9, lost entirely
      start_txn("rnd", 64'h0100_0100_0001_0100, 64'hFF00_0000_1234_0100, 16'h0080, 16'h0100);
      wait_valid("rnd");
      check_result("rnd", 64'hFF80_0080_1234_0180, 3'b001, 4'b0000);
      handshake("rnd");

      // Backpressure: hold out_ready low for 5 cycles with in_valid pulses
      out_ready = 1'b0;
      start_txn("bp", 64'h0100_0100_0100_0100, 64'h0000_0500_FF00_7E00, 16'h0080, 16'h0200);
      wait_valid("bp");
      check_result("bp", 64'h0100_0600_0000_7F00, 3'b000, 4'b0000);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in = 64'h0100_0100_0100_0100; weight = 64'h1111_2222_3333_4444;
         rate = 16'h0100; error = 16'h0100;
         @(posedge clk); #1;
         check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
         check("bp_hold_ready", {63'd0, in_ready}, 64'd0);
         check("bp_hold_nw", new_weight, 64'h0100_0600_0000_7F00);
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      handshake("bp");
      check("bp_after_nw", new_weight, 64'h0100_0600_0000_7F00);

      // Reset asserted mid-RUN (T0+3) aborts the transaction
      start_txn("rst_mid", 64'h0100_0100_0100_0100, 64'h0100_FFC0_0000_0040, 16'h0080, 16'h0200);
      repeat (3) @(posedge clk);
      #1 reset_ = 1'b0;
      #1;
      check("rstmid_ready", {63'd0, in_ready}, 64'd1);
      check("rstmid_valid", {63'd0, out_valid}, 64'd0);
      check_result("rstmid", 64'd0, 3'b000, 4'b0000);
      @(negedge clk);
      reset_ = 1'b1;
      seen = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) seen = 1;
      end
      check("rstmid_no_valid", 64'(seen), 64'd0);
      start_txn("post_rst", 64'h0100_0100_0001_0100, 64'hFF00_0000_1234_0100, 16'h0080, 16'h0100);
      wait_valid("post_rst");
      check_result("post_rst", 64'hFF80_0080_1234_0180, 3'b001, 4'b0000);
      handshake("post_rst");

      // Back-to-back: in_valid held; second accept one cycle after handshake
      @(negedge clk);
      in = 64'h0100_0100_0100_0100; weight = 64'h0000_7F00_0000_0000;
      rate = 16'h0100; error = 16'h0200; in_valid = 1'b1;
      @(posedge clk); #1;
      check("b2b_first_busy", {63'd0, in_ready}, 64'd0);
      weight = 64'h0100_FFC0_0000_0040; rate = 16'h0080; error = 16'h0200;
      wait_valid("b2b_first");
      check_result("b2b_first", EXP_OVF_NW, 3'b100, 4'b0100);
      handshake("b2b_first");
      @(posedge clk); #1;
      check("b2b_second_accept", {63'd0, in_ready}, 64'd0);
      in_valid = 1'b0;
      in = 64'hDEAD_BEEF_1357_9BDF; weight = 64'h7654_3210_FEDC_BA98;
      wait_valid("b2b_second");
      check_result("b2b_second", 64'h0200_00C0_0100_0140, 3'b000, 4'b0000);
      handshake("b2b_second");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
